// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op codes, sequencer states and
// the default operand width.
package alu_pkg;

    localparam int ALU_WIDTH = 128;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOT = 3'b011,
        OP_INC = 3'b100,
        OP_ADD = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only INC and ADD report a carry out of the MSB.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_INC) || (op == OP_ADD);
    endfunction

    // Codes 110 and 111 are not assigned to any operation.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// Combinational STEP-bit ALU slice; the carry ripples from bit 0 upward and
// leaves through cout so the sequencer can chain it into the next cycle.
module alu_serial_slice
    import alu_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] a_bits,
    input  logic [STEP-1:0] b_bits,
    input  logic [2:0]      sel,
    input  logic            cin,
    output logic [STEP-1:0] r_bits,
    output logic            cout
);

    always_comb begin
        logic w_carry;
        // NOTE: every output gets a default before the loop; a path that
        // skips an assignment would otherwise infer a latch.
        r_bits  = '0;
        w_carry = cin;
        for (int i = 0; i < STEP; i++) begin
            case (sel)
                OP_AND: r_bits[i] = a_bits[i] & b_bits[i];
                OP_OR:  r_bits[i] = a_bits[i] | b_bits[i];
                OP_XOR: r_bits[i] = a_bits[i] ^ b_bits[i];
                OP_NOT: r_bits[i] = ~a_bits[i];
                OP_INC: begin
                    r_bits[i] = a_bits[i] ^ w_carry;
                    w_carry   = a_bits[i] & w_carry;
                end
                OP_ADD: begin
                    r_bits[i] = a_bits[i] ^ b_bits[i] ^ w_carry;
                    w_carry   = (a_bits[i] & b_bits[i]) | (w_carry & (a_bits[i] ^ b_bits[i]));
                end
                default: r_bits[i] = 1'b0;
            endcase
        end
        cout = w_carry;
    end

endmodule

// File: rtl/alu128_serial_seq.sv
// Bit-serial ALU sequencer: accepts one operation, processes STEP bits per
// cycle LSB-first for WIDTH/STEP cycles, then holds the result until taken.
module alu128_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             err,
    output logic             busy
);

    localparam int NUM_STEPS = WIDTH / STEP;
    localparam int CNT_W     = $clog2(NUM_STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

    if (STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_step
        $error("alu128_serial_seq: WIDTH must be a positive multiple of STEP");
    end

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_err;
    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [STEP-1:0]  w_r_bits;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_next;

    alu_serial_slice #(.STEP(STEP)) u_slice (
        .a_bits (r_a[STEP-1:0]),
        .b_bits (r_b[STEP-1:0]),
        .sel    (r_sel),
        .cin    (r_carry),
        .r_bits (w_r_bits),
        .cout   (w_cout)
    );

    // New slice bits enter at the MSB end, so after the last step the first
    // slice processed sits at bit 0.
    if (WIDTH == STEP) begin : g_acc_single
        assign w_acc_next = w_r_bits;
    end else begin : g_acc_shift
        assign w_acc_next = {w_r_bits, r_acc[WIDTH-1:STEP]};
    end

    assign w_last    = (r_cnt == LAST_CNT);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign err       = r_err;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Visible outputs load only on the final step, so they keep the previous
    // operation's values while a new one is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole datapath is cleared on reset because the cleared
            // result, carry_out and err are observable right after reset.
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sel   <= sel;
            r_cnt   <= '0;
            r_carry <= (sel == OP_INC);
        end else if (w_step) begin
            r_a     <= r_a >> STEP;
            r_b     <= r_b >> STEP;
            r_acc   <= w_acc_next;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result    <= w_acc_next;
                r_carry_out <= op_is_arith(r_sel) & w_cout;
                r_err       <= op_is_illegal(r_sel);
            end
        end
    end

endmodule

// File: doc/alu128_serial_seq.md
ALU128_SERIAL_SEQ -- requirements
Module: alu128_serial_seq

Interface
REQ-001 Parameter WIDTH, default 128: operand and result width in bits.
REQ-002 Parameter STEP, default 1: bits processed per cycle; WIDTH % STEP SHALL be 0, else elaboration error.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand bundle (a, b, sel) valid.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 sel  input  3  op code: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 INC (A+1), 101 ADD (A+B), 11x illegal.
REQ-010 out_valid  output  1  result, carry_out and err valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 carry_out  output  1  carry out of the MSB for INC/ADD; 0 for all other ops.
REQ-014 err  output  1  set when the completed op had an illegal sel.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid=1, latch a, b, sel; clear the step counter; carry register = 1 if sel=100, else 0; go to RUN.
REQ-018 RUN: each cycle, process operand bits [STEP-1:0] LSB-first; shift the operand registers right by STEP; shift the STEP result bits into the result register from the MSB end; update the carry register; increment the counter.
REQ-019 RUN SHALL last exactly WIDTH/STEP cycles, then go to DONE; out_valid SHALL first be high WIDTH/STEP+1 rising edges after the accepting edge.
REQ-020 Per-bit ops: AND a&b; OR a|b; XOR a^b; NOT ~a (b ignored); INC a+carry; ADD a+b+carry; ripple carry across the STEP bits within a cycle and across cycles via the carry register.
REQ-021 Results SHALL be modulo 2^WIDTH; carry_out = final carry register for INC/ADD, 0 otherwise.
REQ-022 Illegal sel (11x): run the full WIDTH/STEP cycles; result=0, carry_out=0, err=1.
REQ-023 DONE: out_valid=1, in_ready=0; result, carry_out and err held stable until out_ready=1; on out_valid&&out_ready go to IDLE.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid in those states is ignored and not queued.
REQ-025 result, carry_out and err SHALL hold their last values outside DONE; only out_valid qualifies them.

Reset
REQ-026 rst=1 at a clock edge SHALL, from any state, force IDLE, clear the counter, carry, operand and result registers, carry_out and err.
REQ-027 After reset: in_ready=1, out_valid=0, busy=0, result=0, carry_out=0, err=0.
REQ-028 Reset during RUN or DONE SHALL discard the operation; no out_valid SHALL be produced for it.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-030 Shared package alu_pkg SHALL hold the op-code enum (OP_AND..OP_ADD), the FSM state enum and the WIDTH default.
REQ-031 One combinational sub-module alu_serial_slice SHALL implement the STEP-bit slice (inputs a_bits, b_bits, sel, cin; outputs r_bits, cout); the sequencer instantiates it once.

Verification
REQ-032 AND: a=all ones, b=0x5555...5, sel=000 -> result=0x5555...5, carry_out=0, err=0, out_valid exactly 129 edges after accept (STEP=1).
REQ-033 INC wrap: a=all ones, sel=100 -> result=0, carry_out=1; a=0x0F -> result=0x10, carry_out=0.
REQ-034 ADD, STEP=4: a=1, b=all ones -> result=0, carry_out=1, out_valid 33 edges after accept; a=3, b=4 -> result=7, carry_out=0.
REQ-035 Backpressure: out_ready held low 10 cycles in DONE -> result stable, out_valid=1, in_ready=0, second in_valid ignored; IDLE on the edge after out_ready=1.
REQ-036 Reset mid-op: rst high on RUN cycle 60 -> next cycle in_ready=1, out_valid=0, result=0; no result emitted for the aborted op.
REQ-037 Illegal op: sel=110, a=b=all ones -> result=0, carry_out=0, err=1 after the normal latency.
